// File: rtl/dt_pkg.sv
// Shared types and packed-node layout helpers for the sequential decision-tree classifier.
package dt_pkg;

  typedef enum logic [1:0] {IDLE, WALK, DONE} dt_state_e;

  localparam int DT_N = 8;
  localparam int DT_C = 1;
  localparam int DT_F = 6;
  localparam int DT_M = 16;
  localparam int DT_H = 3;

  // Node layout from MSB: {leaf, fidx, thr, left, right, cls}
  function automatic int dt_off_cls();
    return 0;
  endfunction

  function automatic int dt_off_right(input int c);
    return c;
  endfunction

  function automatic int dt_off_left(input int c, input int aw);
    return c + aw;
  endfunction

  function automatic int dt_off_thr(input int c, input int aw);
    return c + 2 * aw;
  endfunction

  function automatic int dt_off_fidx(input int n, input int c, input int aw);
    return c + 2 * aw + n;
  endfunction

  function automatic int dt_off_leaf(input int n, input int c, input int aw, input int fw);
    return c + 2 * aw + n + fw;
  endfunction

  function automatic int dt_node_w(input int n, input int c, input int aw, input int fw);
    return dt_off_leaf(n, c, aw, fw) + 1;
  endfunction

endpackage

// File: rtl/dt_hyst_filter.sv
// Class hysteresis: the held class changes only after H consecutive differing results.
// Present only when DT_HYST_EN is defined.
`ifdef DT_HYST_EN
module dt_hyst_filter #(
  parameter int C = 1,
  parameter int H = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         upd,
  input  logic [C-1:0] raw,
  input  logic         err,
  output logic [C-1:0] held
);

  localparam int CW = $clog2(H + 1);

  logic [CW-1:0] cnt;

  // Aborted walks carry no class information, so they leave the filter untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      held <= '0;
    end else if (upd && !err) begin
      if (raw == held) begin
        cnt <= '0;
      end else if (cnt == CW'(H - 1)) begin
        held <= raw;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
`endif

// File: rtl/dt_seq_classifier.sv
// Programmable decision-tree classifier: walks a loadable node table one node per clock.
// Define DT_HYST_EN to filter the reported class through dt_hyst_filter.
module dt_seq_classifier
  import dt_pkg::*;
#(
  parameter int N = DT_N,
  parameter int C = DT_C,
  parameter int F = DT_F,
  parameter int M = DT_M,
  parameter int H = DT_H
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [F*N-1:0]                           in_feat,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [C-1:0]                             out_cls,
  output logic                                     out_err,
  input  logic                                     cfg_we,
  input  logic [$clog2(M)-1:0]                     cfg_addr,
  input  logic [1+$clog2(F)+N+2*$clog2(M)+C-1:0]   cfg_node
);

  localparam int AW = $clog2(M);
  localparam int FW = $clog2(F);
  localparam int NW = dt_node_w(N, C, AW, FW);

  localparam int OFF_CLS   = dt_off_cls();
  localparam int OFF_RIGHT = dt_off_right(C);
  localparam int OFF_LEFT  = dt_off_left(C, AW);
  localparam int OFF_THR   = dt_off_thr(C, AW);
  localparam int OFF_FIDX  = dt_off_fidx(N, C, AW);
  localparam int OFF_LEAF  = dt_off_leaf(N, C, AW, FW);

  localparam logic [NW-1:0] NODE_RST = {1'b1, {(NW-1){1'b0}}};

  if (H < 1) begin : g_h_check
    $error("dt_seq_classifier: H must be at least 1");
  end

  dt_state_e      state, state_n;
  logic [NW-1:0]  node_mem [M];
  logic [F*N-1:0] feat_q;
  logic [AW-1:0]  cur, step;
  logic           err_q;
  logic           accept, finish, abort;

  logic [NW-1:0]  node;
  logic           n_leaf;
  logic [FW-1:0]  n_fidx;
  logic [N-1:0]   n_thr;
  logic [AW-1:0]  n_left, n_right;
  logic [C-1:0]   n_cls;
  logic [N-1:0]   sel_feat;
  logic           fidx_ok;
  logic           go_left;

  assign node    = node_mem[cur];
  assign n_leaf  = node[OFF_LEAF];
  assign n_fidx  = node[OFF_FIDX +: FW];
  assign n_thr   = node[OFF_THR +: N];
  assign n_left  = node[OFF_LEFT +: AW];
  assign n_right = node[OFF_RIGHT +: AW];
  assign n_cls   = node[OFF_CLS +: C];

  // An out-of-range feature index never compares true, so the walk goes right
  always_comb begin
    sel_feat = '0;
    fidx_ok  = 1'b0;
    for (int i = 0; i < F; i++) begin
      if (int'(n_fidx) == i) begin
        sel_feat = feat_q[i*N +: N];
        fidx_ok  = 1'b1;
      end
    end
  end

  assign go_left  = fidx_ok && (sel_feat < n_thr);
  assign in_ready = (state == IDLE);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    finish  = 1'b0;
    abort   = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_n = WALK;
        end
      end
      WALK: begin
        if (n_leaf) begin
          finish  = 1'b1;
          state_n = DONE;
        end else if (step == AW'(M - 2)) begin
          finish  = 1'b1;
          abort   = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // NOTE: the node table is reset on purpose: an unloaded tree must classify as 0 at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < M; i++) node_mem[i] <= NODE_RST;
    end else if (cfg_we && state == IDLE) begin
      node_mem[cfg_addr] <= cfg_node;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      feat_q    <= '0;
      cur       <= '0;
      step      <= '0;
      err_q     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= (state_n == DONE);
      if (accept) begin
        feat_q <= in_feat;
        cur    <= '0;
        step   <= '0;
      end else if (state == WALK && !finish) begin
        cur  <= go_left ? n_left : n_right;
        step <= step + 1'b1;
      end
      if (finish) err_q <= abort;
    end
  end

  assign out_err = err_q;

`ifdef DT_HYST_EN
  dt_hyst_filter #(
    .C(C),
    .H(H)
  ) u_hyst (
    .clk  (clk),
    .rst  (rst),
    .upd  (finish),
    .raw  (n_cls),
    .err  (abort),
    .held (out_cls)
  );
`else
  logic [C-1:0] cls_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cls_q <= '0;
    else if (finish) cls_q <= abort ? '0 : n_cls;
  end

  assign out_cls = cls_q;
`endif

endmodule

// File: tb/tb_dt_seq_classifier.sv
// Directed bench for dt_seq_classifier: scoreboard of expected class/err/latency per sample.
module tb_dt_seq_classifier;

  localparam int TB_M = 16;
  localparam int TB_H = 3;

  typedef struct {
    logic cls;
    logic err;
    int   lat;
  } sb_item_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] in_feat;
  logic        out_valid;
  logic        out_ready;
  logic [0:0]  out_cls;
  logic        out_err;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [20:0] cfg_node;

  int errors = 0;
  int checks = 0;

  sb_item_t sb_q[$];

  // Reference model of the optional class filter
  logic m_held;
  int   m_cnt;

  dt_seq_classifier dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_feat   (in_feat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_cls   (out_cls),
    .out_err   (out_err),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_node  (cfg_node)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [20:0] mknode(input logic leaf, input logic [2:0] fidx,
                                         input logic [7:0] thr, input logic [3:0] left,
                                         input logic [3:0] right, input logic cls);
    return {leaf, fidx, thr, left, right, cls};
  endfunction

  function automatic logic [47:0] mkfeat(input logic [7:0] va, input logic [7:0] vb,
                                         input logic [7:0] vc, input logic [7:0] ia,
                                         input logic [7:0] ib, input logic [7:0] ic);
    return {ic, ib, ia, vc, vb, va};
  endfunction

  task automatic model_cls(input logic raw, input logic err, output logic exp);
`ifdef DT_HYST_EN
    if (!err) begin
      if (raw == m_held) begin
        m_cnt = 0;
      end else begin
        m_cnt++;
        if (m_cnt == TB_H) begin
          m_held = raw;
          m_cnt  = 0;
        end
      end
    end
    exp = m_held;
`else
    exp = err ? 1'b0 : raw;
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    m_held = 1'b0;
    m_cnt  = 0;
  endtask

  task automatic write_node(input logic [3:0] addr, input logic [20:0] nd);
    cfg_we   = 1'b1;
    cfg_addr = addr;
    cfg_node = nd;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  // wr_when: 0 = no write, 1 = write in the acceptance cycle, 2 = write in the first walk cycle
  task automatic run_sample(input string tag, input logic [47:0] feat, input logic raw_cls,
                            input logic exp_err, input int exp_lat, input int hold,
                            input int wr_when, input logic [3:0] wr_addr,
                            input logic [20:0] wr_node);
    sb_item_t item;
    sb_item_t got;
    logic     exp_cls;
    int       lat;
    model_cls(raw_cls, exp_err, exp_cls);
    item.cls = exp_cls;
    item.err = exp_err;
    item.lat = exp_lat;
    sb_q.push_back(item);

    check({tag, "/in_ready_idle"}, 32'(in_ready), 32'd1);
    in_feat  = feat;
    in_valid = 1'b1;
    if (wr_when == 1) begin
      cfg_we   = 1'b1;
      cfg_addr = wr_addr;
      cfg_node = wr_node;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    if (wr_when == 2) begin
      cfg_we   = 1'b1;
      cfg_addr = wr_addr;
      cfg_node = wr_node;
    end

    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    check({tag, "/out_valid_seen"}, 32'(out_valid), 32'd1);

    got = sb_q.pop_front();
    check({tag, "/latency"}, 32'(lat), 32'(got.lat));
    check({tag, "/cls"}, 32'(out_cls), 32'(got.cls));
    check({tag, "/err"}, 32'(out_err), 32'(got.err));

    for (int c = 0; c < hold; c++) begin
      @(posedge clk);
      #1;
      check({tag, "/hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "/hold_cls"}, 32'(out_cls), 32'(got.cls));
      check({tag, "/hold_err"}, 32'(out_err), 32'(got.err));
      check({tag, "/hold_in_ready"}, 32'(in_ready), 32'd0);
    end

    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "/release_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "/release_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_feat   = '0;
    out_ready = 1'b0;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_node  = '0;
    m_held    = 1'b0;
    m_cnt     = 0;
    #12;
    do_reset();

    check("reset/in_ready", 32'(in_ready), 32'd1);
    check("reset/out_valid", 32'(out_valid), 32'd0);
    check("reset/out_cls", 32'(out_cls), 32'd0);
    check("reset/out_err", 32'(out_err), 32'd0);

    run_sample("reset_default", '0, 1'b0, 1'b0, 1, 0, 0, '0, '0);

    // Depth-4 tree: Ib<119 -> Va<196 -> Vb<63 -> Ib<111 -> leaf 1; every false side -> leaf 0
    write_node(4'd0, mknode(1'b0, 3'd4, 8'd119, 4'd1, 4'd5, 1'b0));
    write_node(4'd1, mknode(1'b0, 3'd0, 8'd196, 4'd2, 4'd5, 1'b0));
    write_node(4'd2, mknode(1'b0, 3'd1, 8'd63,  4'd3, 4'd5, 1'b0));
    write_node(4'd3, mknode(1'b0, 3'd4, 8'd111, 4'd4, 4'd5, 1'b0));
    write_node(4'd4, mknode(1'b1, 3'd0, 8'd0,   4'd0, 4'd0, 1'b1));
    write_node(4'd5, mknode(1'b1, 3'd0, 8'd0,   4'd0, 4'd0, 1'b0));

    run_sample("depth4_leaf1", mkfeat(100, 50, 0, 0, 100, 0), 1'b1, 1'b0, 5, 0, 0, '0, '0);
    run_sample("ib_120",       mkfeat(100, 50, 0, 0, 120, 0), 1'b0, 1'b0, 2, 0, 0, '0, '0);
    run_sample("ib_eq_thr",    mkfeat(100, 50, 0, 0, 119, 0), 1'b0, 1'b0, 2, 0, 0, '0, '0);
    run_sample("ib_111_node3", mkfeat(100, 50, 0, 0, 111, 0), 1'b0, 1'b0, 5, 0, 0, '0, '0);
    run_sample("va_eq_thr",    mkfeat(196, 50, 0, 0, 100, 0), 1'b0, 1'b0, 3, 0, 0, '0, '0);
    run_sample("vb_eq_thr",    mkfeat(100, 63, 0, 0, 100, 0), 1'b0, 1'b0, 4, 0, 0, '0, '0);

    run_sample("backpressure", mkfeat(100, 50, 0, 0, 110, 0), 1'b1, 1'b0, 5, 10, 0, '0, '0);

    // A write during WALK is dropped; the following sample still walks the old root
    run_sample("walk_write", mkfeat(100, 50, 0, 0, 100, 0), 1'b1, 1'b0, 5, 0, 2, 4'd0,
               mknode(1'b1, 3'd0, 8'd0, 4'd0, 4'd0, 1'b0));
    run_sample("old_root", mkfeat(100, 50, 0, 0, 100, 0), 1'b1, 1'b0, 5, 0, 0, '0, '0);
    write_node(4'd0, mknode(1'b1, 3'd0, 8'd0, 4'd0, 4'd0, 1'b0));
    run_sample("idle_write", mkfeat(100, 50, 0, 0, 100, 0), 1'b0, 1'b0, 1, 0, 0, '0, '0);

    run_sample("write_with_accept", mkfeat(100, 50, 0, 0, 100, 0), 1'b1, 1'b0, 1, 0, 1, 4'd0,
               mknode(1'b1, 3'd0, 8'd0, 4'd0, 4'd0, 1'b1));

    write_node(4'd0, mknode(1'b0, 3'd0, 8'd0, 4'd0, 4'd0, 1'b0));
    run_sample("loop_abort", mkfeat(5, 0, 0, 0, 0, 0), 1'b0, 1'b1, TB_M - 1, 0, 0, '0, '0);

    write_node(4'd0, mknode(1'b0, 3'd7, 8'd255, 4'd1, 4'd2, 1'b0));
    write_node(4'd1, mknode(1'b1, 3'd0, 8'd0, 4'd0, 4'd0, 1'b0));
    write_node(4'd2, mknode(1'b1, 3'd0, 8'd0, 4'd0, 4'd0, 1'b1));
    run_sample("fidx_out_of_range", '0, 1'b1, 1'b0, 2, 0, 0, '0, '0);

    // Reset during a walk discards the sample and restores the default table
    write_node(4'd0, mknode(1'b0, 3'd0, 8'd0, 4'd0, 4'd0, 1'b0));
    in_feat  = '0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midwalk_reset/in_ready", 32'(in_ready), 32'd1);
    check("midwalk_reset/out_valid", 32'(out_valid), 32'd0);
    check("midwalk_reset/out_err", 32'(out_err), 32'd0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    m_held = 1'b0;
    m_cnt  = 0;
    run_sample("post_reset_table", mkfeat(9, 9, 9, 9, 9, 9), 1'b0, 1'b0, 1, 0, 0, '0, '0);

    // Raw class sequence 1,1,0,1,1,1 (filtered build reports 0,0,0,0,0,1)
    do_reset();
    write_node(4'd0, mknode(1'b0, 3'd0, 8'd128, 4'd1, 4'd2, 1'b0));
    write_node(4'd1, mknode(1'b1, 3'd0, 8'd0, 4'd0, 4'd0, 1'b1));
    write_node(4'd2, mknode(1'b1, 3'd0, 8'd0, 4'd0, 4'd0, 1'b0));
    run_sample("seq_1", mkfeat(0,   0, 0, 0, 0, 0), 1'b1, 1'b0, 2, 0, 0, '0, '0);
    run_sample("seq_2", mkfeat(0,   0, 0, 0, 0, 0), 1'b1, 1'b0, 2, 0, 0, '0, '0);
    run_sample("seq_3", mkfeat(200, 0, 0, 0, 0, 0), 1'b0, 1'b0, 2, 0, 0, '0, '0);
    run_sample("seq_4", mkfeat(0,   0, 0, 0, 0, 0), 1'b1, 1'b0, 2, 0, 0, '0, '0);
    run_sample("seq_5", mkfeat(0,   0, 0, 0, 0, 0), 1'b1, 1'b0, 2, 0, 0, '0, '0);
    run_sample("seq_6", mkfeat(127, 0, 0, 0, 0, 0), 1'b1, 1'b0, 2, 0, 0, '0, '0);

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
